clock_time_counter: RTL and testbench

- Timekeeping core of the digital clock.
- Divides the system clock to a 1 Hz tick and maintains seconds (0-59), minutes (0-59) and hours (0-23).
- Each 6-bit value feeds directly into a two-digit 0-59 seven-segment decoder, one decoder instance per field.
- Provides a set mode in which the user advances minutes and hours with pre-debounced single-cycle pulses.

---
 rtl/clock_time_counter_pkg.sv | 16 +
 rtl/clock_time_counter_if.sv | 39 +++
 rtl/clock_time_counter_mod_n_counter.sv | 43 ++++
 rtl/clock_time_counter.sv | 121 ++++++++++++
 tb/tb_clock_time_counter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_time_counter_pkg.sv
// Shared constants and state encoding for the clock timekeeping core.
// Optional alarm logic elsewhere is enabled by defining CLOCK_ALARM_EN.
package clock_pkg;

    localparam int TIME_W  = 6;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        SET  = 2'd2
    } state_e;

endpackage

// File: rtl/clock_time_counter_if.sv
// Control and time-display bundle of the clock core.
// With CLOCK_ALARM_EN defined the bundle also carries the alarm setpoint and flag.
interface clock_time_counter_if;
    import clock_pkg::*;

    logic              run;
    logic              set_mode;
    logic              inc_min;
    logic              inc_hr;
    logic [TIME_W-1:0] seconds;
    logic [TIME_W-1:0] minutes;
    logic [TIME_W-1:0] hours;
    logic              tick_1hz;
`ifdef CLOCK_ALARM_EN
    logic              alarm_on;
    logic [TIME_W-1:0] alarm_hr;
    logic [TIME_W-1:0] alarm_min;
    logic              alarm;

    modport master (
        output run, set_mode, inc_min, inc_hr, alarm_on, alarm_hr, alarm_min,
        input  seconds, minutes, hours, tick_1hz, alarm
    );
    modport slave (
        input  run, set_mode, inc_min, inc_hr, alarm_on, alarm_hr, alarm_min,
        output seconds, minutes, hours, tick_1hz, alarm
    );
`else
    modport master (
        output run, set_mode, inc_min, inc_hr,
        input  seconds, minutes, hours, tick_1hz
    );
    modport slave (
        input  run, set_mode, inc_min, inc_hr,
        output seconds, minutes, hours, tick_1hz
    );
`endif

endinterface

// File: rtl/clock_time_counter_mod_n_counter.sv
// Wrapping 0..MAX counter with synchronous clear; carry flags the wrap
// combinationally so chained counters all roll over on the same edge.
module mod_n_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59,
    parameter int W   = TIME_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_q, value_d;
    logic         at_max;

    assign at_max = (value_q == MAX_V);
    assign carry  = inc & at_max;
    assign value  = value_q;

    // Compare-to-max then wrap; clear wins over increment.
    always_comb begin
        value_d = value_q;
        if (clr)
            value_d = '0;
        else if (inc)
            value_d = at_max ? '0 : value_q + 1'b1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst)
            value_q <= '0;
        else
            value_q <= value_d;
    end

endmodule

// File: rtl/clock_time_counter.sv
// Timekeeping core: prescales clk to a 1 Hz tick and keeps HH:MM:SS.
// Set mode lets the user bump minutes/hours with single-cycle pulses.
// Define CLOCK_ALARM_EN to add the registered alarm comparator.
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    clock_time_counter_if.slave  bus
);

    localparam int             PS_W   = $clog2(CLK_DIV);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

    state_e          state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_q, tick_d;

    logic            in_set;
    logic            wrap;
    logic            sec_carry, min_carry;
    logic            min_inc, hr_inc;

    assign in_set = (state_q == SET);
    assign wrap   = (state_q == RUN) && (ps_q == PS_MAX);

    // Mode selection: set_mode dominates run, evaluated every cycle.
    always_comb begin
        state_d = STOP;
        if (bus.set_mode)
            state_d = SET;
        else if (bus.run)
            state_d = RUN;
    end

    // Prescaler: counts only in RUN, parked at 0 in SET, held in STOP.
    always_comb begin
        ps_d   = ps_q;
        tick_d = 1'b0;
        case (state_q)
            RUN: begin
                ps_d   = wrap ? '0 : ps_q + 1'b1;
                tick_d = wrap;
            end
            SET:     ps_d = '0;
            default: ps_d = ps_q;
        endcase
    end

    // In SET the user pulses drive minutes/hours directly and the carry
    // chain is cut, so bumping minutes past 59 never touches hours.
    assign min_inc = in_set ? bus.inc_min : sec_carry;
    assign hr_inc  = in_set ? bus.inc_hr  : min_carry;

    mod_n_counter #(.MAX(SEC_MAX), .W(TIME_W)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (wrap),
        .clr   (in_set),
        .value (bus.seconds),
        .carry (sec_carry)
    );

    mod_n_counter #(.MAX(MIN_MAX), .W(TIME_W)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (bus.minutes),
        .carry (min_carry)
    );

    // Hours wrap 23->0 with no day carry, so its carry is left open.
    mod_n_counter #(.MAX(HR_MAX), .W(TIME_W)) u_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   (hr_inc),
        .clr   (1'b0),
        .value (bus.hours),
        .carry ()
    );

    // State, prescaler and tick registers; reset overrides any pending work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STOP;
            ps_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.tick_1hz = tick_q;

`ifdef CLOCK_ALARM_EN
    logic alarm_q, alarm_d;

    // Alarm compares the currently displayed time, so it lags a match by one cycle.
    always_comb begin
        alarm_d = bus.alarm_on & ~in_set
                & (bus.hours == bus.alarm_hr)
                & (bus.minutes == bus.alarm_min);
    end

    // Alarm flag register.
    always_ff @(posedge clk) begin
        if (rst)
            alarm_q <= 1'b0;
        else
            alarm_q <= alarm_d;
    end

    assign bus.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench for clock_time_counter (CLK_DIV = 4).
// The reference keeps time as seconds-of-day and derives H/M/S arithmetically.
module tb_clock_time_counter;

    localparam int CLK_DIV = 4;
    localparam int DAY     = 86400;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_time_counter_if bus_if ();

    clock_time_counter #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: mode 0=stopped 1=running 2=setting.
    int m_t     = 0;
    int m_ps    = 0;
    int m_mode  = 0;
    int m_tick  = 0;
    int m_alarm = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int m_hr();
        return m_t / 3600;
    endfunction

    function automatic int m_min();
        return (m_t / 60) % 60;
    endfunction

    function automatic int m_sec();
        return m_t % 60;
    endfunction

    // One clock edge of the reference, using the inputs held across the edge.
    task automatic model_step();
        int h, m;
        h = m_hr();
        m = m_min();
        if (rst) begin
            m_t = 0; m_ps = 0; m_mode = 0; m_tick = 0; m_alarm = 0;
        end else begin
`ifdef CLOCK_ALARM_EN
            m_alarm = (bus_if.alarm_on && m_mode != 2 &&
                       h == int'(bus_if.alarm_hr) && m == int'(bus_if.alarm_min)) ? 1 : 0;
`endif
            m_tick = 0;
            if (m_mode == 1) begin
                if (m_ps == CLK_DIV - 1) begin
                    m_ps   = 0;
                    m_t    = (m_t + 1) % DAY;
                    m_tick = 1;
                end else begin
                    m_ps++;
                end
            end else if (m_mode == 2) begin
                m_ps = 0;
                if (bus_if.inc_min) m = (m + 1) % 60;
                if (bus_if.inc_hr)  h = (h + 1) % 24;
                m_t = h * 3600 + m * 60;
            end
            m_mode = bus_if.set_mode ? 2 : (bus_if.run ? 1 : 0);
        end
    endtask

    // Advance one cycle and compare every output against the reference.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("seconds", int'(bus_if.seconds), m_sec());
        chk("minutes", int'(bus_if.minutes), m_min());
        chk("hours",   int'(bus_if.hours),   m_hr());
        chk("tick",    int'(bus_if.tick_1hz), m_tick);
`ifdef CLOCK_ALARM_EN
        chk("alarm",   int'(bus_if.alarm),   m_alarm);
`endif
    endtask

    task automatic pulse(input logic im, input logic ih);
        bus_if.inc_min = im;
        bus_if.inc_hr  = ih;
        cyc();
        bus_if.inc_min = 1'b0;
        bus_if.inc_hr  = 1'b0;
    endtask

    function automatic int hms();
        return int'(bus_if.hours) * 10000 + int'(bus_if.minutes) * 100 + int'(bus_if.seconds);
    endfunction

    initial begin
        logic im, ih;
        bus_if.run      = 1'b0;
        bus_if.set_mode = 1'b0;
        bus_if.inc_min  = 1'b0;
        bus_if.inc_hr   = 1'b0;
`ifdef CLOCK_ALARM_EN
        bus_if.alarm_on  = 1'b0;
        bus_if.alarm_hr  = '0;
        bus_if.alarm_min = '0;
`endif

        // Reset, then the first tick after entering RUN.
        rst = 1'b1;
        repeat (2) cyc();
        chk("rst_hms",  hms(), 0);
        chk("rst_tick", int'(bus_if.tick_1hz), 0);
        rst = 1'b0;
        bus_if.run = 1'b1;
        repeat (CLK_DIV) cyc();
        chk("pre_tick_sec", int'(bus_if.seconds), 0);
        cyc();
        chk("first_tick",     int'(bus_if.tick_1hz), 1);
        chk("first_tick_sec", int'(bus_if.seconds), 1);
        repeat (3) cyc();

        // SET edits: hours to 22, then 22->23->0->1.
        bus_if.set_mode = 1'b1;
        cyc();
        repeat (22) pulse(1'b0, 1'b1);
        chk("set_hr22", int'(bus_if.hours), 22);
        chk("set_sec0", int'(bus_if.seconds), 0);
        pulse(1'b0, 1'b1); chk("set_hr23", int'(bus_if.hours), 23);
        pulse(1'b0, 1'b1); chk("set_hr0",  int'(bus_if.hours), 0);
        pulse(1'b0, 1'b1); chk("set_hr1",  int'(bus_if.hours), 1);
        repeat (22) pulse(1'b0, 1'b1);
        repeat (59) pulse(1'b1, 1'b0);
        chk("set_2359", hms(), 235900);
        pulse(1'b1, 1'b0);
        chk("min_wrap_no_carry", hms(), 230000);
        repeat (59) pulse(1'b1, 1'b0);

        // Rollover 23:59:59 -> 00:00:00 on the tick edge.
        bus_if.set_mode = 1'b0;
        for (int i = 0; i < 70 * CLK_DIV && m_t != 0; i++) cyc();
        chk("rollover_hms",  hms(), 0);
        chk("rollover_tick", int'(bus_if.tick_1hz), 1);

        // Simultaneous pulses from 00:00 in SET.
        bus_if.set_mode = 1'b1;
        cyc();
        pulse(1'b1, 1'b1);
        chk("both_inc", hms(), 10100);

        // Pulses in RUN are ignored.
        bus_if.set_mode = 1'b0;
        cyc();
        repeat (4) begin pulse(1'b1, 1'b1); cyc(); end
        chk("run_ignores_inc_hm", int'(bus_if.hours) * 100 + int'(bus_if.minutes), 101);

        // Freeze/resume: prescaler holds while stopped.
        rst = 1'b1; cyc(); rst = 1'b0;
        bus_if.run = 1'b1;
        repeat (3) cyc();
        bus_if.run = 1'b0;
        repeat (10) cyc();
        chk("frozen_sec", int'(bus_if.seconds), 0);
        bus_if.run = 1'b1;
        repeat (3 * CLK_DIV + 2) cyc();

        // Reset during SET with a pending inc_min.
        bus_if.set_mode = 1'b1; cyc();
        pulse(1'b1, 1'b0);
        bus_if.inc_min = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0; bus_if.inc_min = 1'b0;
        chk("rst_in_set", hms(), 0);
        bus_if.set_mode = 1'b0;

        // Reset in the cycle a tick would be produced.
        bus_if.run = 1'b1;
        for (int i = 0; i < 4 * CLK_DIV && !(m_mode == 1 && m_ps == CLK_DIV - 1); i++) cyc();
        chk("reached_tick_cycle", m_ps, CLK_DIV - 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_on_tick_hms",  hms(), 0);
        chk("rst_on_tick_tick", int'(bus_if.tick_1hz), 0);

`ifdef CLOCK_ALARM_EN
        // Alarm at 00:02: rises one cycle after minutes==2, falls after minutes==3.
        bus_if.alarm_on = 1'b1; bus_if.alarm_hr = 6'd0; bus_if.alarm_min = 6'd2;
        for (int i = 0; i < 200 * CLK_DIV && m_min() != 2; i++) cyc();
        chk("alarm_pre", int'(bus_if.alarm), 0);
        cyc();
        chk("alarm_rise", int'(bus_if.alarm), 1);
        for (int i = 0; i < 80 * CLK_DIV && m_min() != 3; i++) cyc();
        chk("alarm_hold", int'(bus_if.alarm), 1);
        cyc();
        chk("alarm_fall", int'(bus_if.alarm), 0);
        rst = 1'b1; cyc(); rst = 1'b0;
        bus_if.alarm_on = 1'b0;
        for (int i = 0; i < 200 * CLK_DIV && m_min() != 2; i++) cyc();
        repeat (2) cyc();
        chk("alarm_off", int'(bus_if.alarm), 0);
`endif

        // Randomised mode/pulse/reset traffic against the reference.
        im = 1'b0; ih = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) bus_if.set_mode = ~bus_if.set_mode;
            if ($urandom_range(0, 9) == 0)  bus_if.run = ~bus_if.run;
            im = !im && ($urandom_range(0, 3) == 0);
            ih = !ih && ($urandom_range(0, 3) == 0);
            bus_if.inc_min = im;
            bus_if.inc_hr  = ih;
`ifdef CLOCK_ALARM_EN
            if ($urandom_range(0, 49) == 0) begin
                bus_if.alarm_on  = 1'($urandom_range(0, 1));
                bus_if.alarm_hr  = 6'(m_hr());
                bus_if.alarm_min = 6'((m_min() + $urandom_range(0, 2)) % 60);
            end
`endif
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
